// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_mem_pkg
// Description : Shared definitions for the data-memory responder. Holds the
//               word / byte-enable widths, the responder FSM state encoding
//               and the address legality check used when an access is done.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_mem_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // An address is in error when it is not word aligned or when its word
  // index falls past the end of the array. Alignment is tested first.
  function automatic logic addr_err(input logic [XLEN-1:0] addr,
                                    input int unsigned    depth);
    logic [XLEN-1:0] w_word;
    w_word = {2'b00, addr[XLEN-1:2]};
    return (addr[1:0] != 2'b00) || (w_word >= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_bytemem.sv
`default_nettype none
// ============================================================================
// Module      : rv_bytemem
// Description : DEPTH x 32-bit word array with a synchronous byte-enabled
//               write port and a combinational read port sharing one index.
//               Contents are not reset.
// Ports       : clk   - write clock
//               we    - write strobe (qualified by be)
//               be    - byte enables, bit i writes bits [8i+7:8i]
//               idx   - word index for read and write
//               wdata - write data
//               rdata - word currently held at idx
// Revision    : 1.0 - initial release
// ============================================================================
module rv_bytemem
  import rv_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [BE_W-1:0] be,
  input  logic [AW-1:0]   idx,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = r_mem[idx];

endmodule
`default_nettype wire

// File: rtl/rv_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : rv_dmem_responder
// Description : Memory-side responder for the load/store data path. Accepts
//               one word request at a time, waits LATENCY cycles, performs a
//               load or byte-enabled store on an internal array and returns
//               data / ack on a separate valid/ready response channel.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous active-high reset
//               req_valid  - request present
//               req_ready  - responder idle and able to accept
//               req_we     - 1 = store, 0 = load
//               req_addr   - byte address
//               req_wdata  - store data
//               req_be     - store byte enables (ignored for loads)
//               rsp_valid  - response present
//               rsp_ready  - initiator takes the response
//               rsp_rdata  - load data (0 for stores and errors)
//               rsp_err    - misaligned or out-of-range request
// Revision    : 1.0 - initial release
// ============================================================================
module rv_dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int               c_aw      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_latency = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_we;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [BE_W-1:0]   r_be;

  logic              w_accept;
  logic              w_access;
  logic              w_use_live;
  logic              w_acc_we;
  logic [XLEN-1:0]   w_acc_addr;
  logic [XLEN-1:0]   w_acc_wdata;
  logic [BE_W-1:0]   w_acc_be;
  logic              w_acc_err;
  logic [c_aw-1:0]   w_acc_idx;
  logic              w_mem_we;
  logic [XLEN-1:0]   w_mem_rdata;

  assign req_ready = (r_state == IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;

  // --------------------------------------------------------------------------
  // Next-state decode. w_access marks the single edge at which the array is
  // read or written for the outstanding request.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 0) begin
            w_state_nxt = RESP;
            w_access    = 1'b1;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == c_one) begin
          w_state_nxt = RESP;
          w_access    = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Request capture and wait-state counter. With zero latency the counter
  // is loaded with 0 and never used.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= c_latency;
      end else if (r_state == WAIT) begin
        r_cnt   <= r_cnt - c_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Access operands. With zero latency the access happens on the accept edge
  // itself, before the capture registers hold the request, so the live
  // request inputs are used while still in IDLE.
  // --------------------------------------------------------------------------
  assign w_use_live  = (r_state == IDLE);
  assign w_acc_we    = w_use_live ? req_we    : r_we;
  assign w_acc_addr  = w_use_live ? req_addr  : r_addr;
  assign w_acc_wdata = w_use_live ? req_wdata : r_wdata;
  assign w_acc_be    = w_use_live ? req_be    : r_be;

  assign w_acc_err   = addr_err(w_acc_addr, DEPTH);
  assign w_acc_idx   = w_acc_addr[2 +: c_aw];
  assign w_mem_we    = w_access && w_acc_we && !w_acc_err;

  rv_bytemem #(
    .DEPTH (DEPTH),
    .AW    (c_aw)
  ) u_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .be    (w_acc_be),
    .idx   (w_acc_idx),
    .wdata (w_acc_wdata),
    .rdata (w_mem_rdata)
  );

  // --------------------------------------------------------------------------
  // Response registers: loaded on the access edge, held through any stall,
  // cleared on the handshake edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (w_access) begin
      rsp_valid <= 1'b1;
      rsp_err   <= w_acc_err;
      rsp_rdata <= (w_acc_we || w_acc_err) ? '0 : w_mem_rdata;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_dmem_responder
// Description : Self-checking bench for rv_dmem_responder. Two instances are
//               exercised: one with two wait states and one with none. A
//               word-array model of each instance predicts load data, error
//               flags and response timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;
  localparam int TMO   = 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared request fields; req_valid is steered to the instance under test
  bit          sel;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;

  logic        valid_in_a, valid_in_b;
  logic        ready_a, ready_b, rv_a, rv_b, err_a, err_b;
  logic [31:0] rd_a, rd_b;
  logic        cur_ready, cur_valid, cur_err;
  logic [31:0] cur_rdata;

  assign valid_in_a = req_valid && !sel;
  assign valid_in_b = req_valid && sel;
  assign cur_ready  = sel ? ready_b : ready_a;
  assign cur_valid  = sel ? rv_b    : rv_a;
  assign cur_err    = sel ? err_b   : err_a;
  assign cur_rdata  = sel ? rd_b    : rd_a;

  rv_dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .req_valid(valid_in_a), .req_ready(ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_rdata(rd_a), .rsp_err(err_a)
  );

  rv_dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .req_valid(valid_in_b), .req_ready(ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_rdata(rd_b), .rsp_err(err_b)
  );

  // reference model: word contents plus which bytes have ever been written
  logic [31:0] mdl [2][DEPTH];
  logic [3:0]  kn  [2][DEPTH];

  int n_checks = 0;
  int n_errors = 0;
  int last_acc = 0;
  int prev_acc = 0;

  // One complete transaction on the selected instance; hold > 0 keeps
  // rsp_ready low for that many cycles once the response is up.
  task automatic do_req(input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int hold);
    int          s, idx, waited, exp_lat;
    bit          exp_err, exp_known;
    logic [31:0] exp_rd, h_rd;
    logic        h_err;
    s         = sel ? 1 : 0;
    exp_lat   = sel ? LAT_B : LAT_A;
    exp_err   = (addr % 4 != 0) || ((addr / 4) >= 32'(DEPTH));
    exp_rd    = 32'h0;
    exp_known = 1'b1;
    if (!exp_err) begin
      idx = int'(addr / 4);
      if (!we) begin
        exp_rd    = mdl[s][idx];
        exp_known = (kn[s][idx] == 4'hF);
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            mdl[s][idx][8*b +: 8] = wdata[8*b +: 8];
            kn[s][idx][b]         = 1'b1;
          end
        end
      end
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = (hold == 0);
    n_checks++;
    if (cur_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL req_ready_idle: got %b expected 1 (addr %h)", cur_ready, addr);
    end
    @(posedge clk); #1;
    prev_acc  = last_acc;
    last_acc  = cyc;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);

    waited = 0;
    while (cur_valid !== 1'b1 && waited < TMO) begin
      n_checks++;
      if (cur_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL req_ready_wait: got %b expected 0", cur_ready);
      end
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (waited != exp_lat) begin
      n_errors++;
      $display("FAIL rsp_latency: got %0d cycles expected %0d (addr %h)", waited, exp_lat, addr);
      if (waited >= TMO) return;
    end
    n_checks++;
    if (cur_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL req_ready_resp: got %b expected 0", cur_ready);
    end
    n_checks++;
    if (cur_err !== exp_err) begin
      n_errors++;
      $display("FAIL rsp_err: got %b expected %b (addr %h we %b)", cur_err, exp_err, addr, we);
    end
    if (exp_known) begin
      n_checks++;
      if (cur_rdata !== exp_rd) begin
        n_errors++;
        $display("FAIL rsp_rdata: got %h expected %h (addr %h we %b)", cur_rdata, exp_rd, addr, we);
      end
    end

    h_rd  = cur_rdata;
    h_err = cur_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = $urandom; req_be = 4'hF;
      n_checks++;
      if (cur_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL req_ready_stall: got %b expected 0", cur_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_checks++;
      if (cur_valid !== 1'b1 || cur_rdata !== h_rd || cur_err !== h_err) begin
        n_errors++;
        $display("FAIL rsp_stall_stable: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                 cur_valid, cur_rdata, cur_err, h_rd, h_err);
      end
    end

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (cur_valid !== 1'b0 || cur_rdata !== 32'h0 || cur_err !== 1'b0) begin
      n_errors++;
      $display("FAIL rsp_clear: got v=%b d=%h e=%b expected v=0 d=0 e=0",
               cur_valid, cur_rdata, cur_err);
    end
    n_checks++;
    if (cur_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL req_ready_after: got %b expected 1", cur_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (rv_a !== 1'b0 || rd_a !== 32'h0 || err_a !== 1'b0 ||
        rv_b !== 1'b0 || rd_b !== 32'h0 || err_b !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got a=%b/%h/%b b=%b/%h/%b expected all 0",
               rv_a, rd_a, err_a, rv_b, rd_b, err_b);
    end
    n_checks++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready_low: got %b%b expected 00", ready_a, ready_b);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready_release: got %b%b expected 11", ready_a, ready_b);
    end
  endtask

  task automatic test_store_load();
    sel = 1'b0;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
  endtask

  task automatic test_byte_enable();
    sel = 1'b0;
    do_req(1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
  endtask

  task automatic test_errors();
    sel = 1'b0;
    do_req(1'b0, 32'h13, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h0, 32'h01234567, 4'hF, 0);
    do_req(1'b1, 32'(DEPTH * 4), 32'hA5A5A5A5, 4'hF, 0);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'(DEPTH * 4 - 4), 32'h89ABCDEF, 4'hF, 0);
    do_req(1'b0, 32'(DEPTH * 4 - 4), 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h12, 32'h55555555, 4'hF, 0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 5);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
    sel = 1'b1;
    do_req(1'b1, 32'h10, 32'h0BADCAFE, 4'hF, 5);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    for (int i = 0; i < 8; i++) do_req(1'b1, 32'(i * 4), 32'(i), 4'hF, 0);
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 32'(i * 4), 32'h0, 4'h0, 0);
      if (i > 0) begin
        n_checks++;
        if (last_acc - prev_acc != 2) begin
          n_errors++;
          $display("FAIL accept_spacing: got %0d cycles expected 2", last_acc - prev_acc);
        end
      end
    end
  endtask

  task automatic test_reset_wait();
    sel = 1'b0;
    do_req(1'b1, 32'h20, 32'h5A5A1234, 4'hF, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (ready_a !== 1'b0 || rv_a !== 1'b0) begin
      n_errors++;
      $display("FAIL wait_state: got ready=%b valid=%b expected 0 0", ready_a, rv_a);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (rv_a !== 1'b0 || ready_a !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_in_wait: got valid=%b ready=%b expected 0 0", rv_a, ready_a);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (ready_a !== 1'b1) begin
      n_errors++;
      $display("FAIL idle_after_reset: got ready=%b expected 1", ready_a);
    end
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0);
  endtask

  task automatic test_reset_resp();
    logic [31:0] d;
    int          w;
    sel = 1'b0;
    d   = $urandom;
    mdl[0][9] = d;
    kn[0][9]  = 4'hF;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = d; req_be = 4'hF;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w = 0;
    while (rv_a !== 1'b1 && w < TMO) begin
      @(posedge clk); #1;
      w++;
    end
    n_checks++;
    if (rv_a !== 1'b1) begin
      n_errors++;
      $display("FAIL resp_reached: got valid=%b expected 1", rv_a);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (rv_a !== 1'b0 || rd_a !== 32'h0 || err_a !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_in_resp: got v=%b d=%h e=%b expected 0 0 0", rv_a, rd_a, err_a);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    do_req(1'b0, 32'h24, 32'h0, 4'h0, 0);
  endtask

  task automatic test_random(input bit which);
    sel = which;
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) * 4;
      if (r == 0)      a = a + 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'(DEPTH * 4) + a;
      else if (r == 2) a = 32'((DEPTH - 1) * 4);
      do_req($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom), $urandom_range(0, 2));
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) begin
        mdl[s][i] = 32'h0;
        kn[s][i]  = 4'h0;
      end
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_wait();
    test_reset_resp();
    test_random(1'b0);
    test_random(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
